// File: rtl/rs_scheduler.sv
// Issue, CDB-wakeup and round-robin dispatch control for a bank of add reservation stations.
// Define RS_WAKEUP_BYPASS_EN to count operands arriving on the CDB this cycle as ready.
module rs_scheduler #(
  parameter int NUM_RS    = 3,
  parameter int TAG_WIDTH = 3,
  parameter int IDX_WIDTH = $clog2(NUM_RS)
) (
  input  logic                          clk,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  output logic [IDX_WIDTH-1:0]          alloc_idx,
  output logic [NUM_RS-1:0]             ld_issue,
  input  logic [NUM_RS-1:0]             rs_busy,
  input  logic [NUM_RS-1:0]             rs_Vj_valid,
  input  logic [NUM_RS-1:0]             rs_Vk_valid,
  input  logic [NUM_RS*TAG_WIDTH-1:0]   rs_Qj,
  input  logic [NUM_RS*TAG_WIDTH-1:0]   rs_Qk,
  input  logic                          cdb_valid,
  input  logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [NUM_RS-1:0]             ld_Vj_cdb,
  output logic [NUM_RS-1:0]             ld_Vk_cdb,
  output logic [NUM_RS-1:0]             clr_busy,
  output logic                          exec_valid,
  output logic [IDX_WIDTH-1:0]          exec_idx,
  input  logic                          exec_ready
);

  // Handshake: an offer (exec_valid, exec_idx) is held unchanged until exec_ready is
  // seen high with exec_valid; that cycle is the transfer and frees the entry.
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_e;

  localparam logic [IDX_WIDTH:0] NUM_RS_W = (IDX_WIDTH+1)'(NUM_RS);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] exec_idx_q, exec_idx_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                 free_found;
  logic [IDX_WIDTH-1:0] free_idx;
  logic [NUM_RS-1:0]    ready, cand, rot, exec_oh;
  logic                 accept;
  logic [IDX_WIDTH-1:0] next_ptr, sel_base, sel_off, sel_idx;
  logic [IDX_WIDTH:0]   sel_sum;
  logic                 sel_found;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_RS-1; i >= 0; i--) begin
      if (!rs_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign issue_ready = ~flush & free_found;
  assign alloc_idx   = flush ? '0 : free_idx;
  assign ld_issue    = (issue_valid & issue_ready) ? (NUM_RS'(1) << free_idx) : '0;

  always_comb begin
    ld_Vj_cdb = '0;
    ld_Vk_cdb = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      ld_Vj_cdb[i] = ~flush & cdb_valid & rs_busy[i] & ~rs_Vj_valid[i] &
                     (rs_Qj[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag);
      ld_Vk_cdb[i] = ~flush & cdb_valid & rs_busy[i] & ~rs_Vk_valid[i] &
                     (rs_Qk[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  assign ready = rs_busy & (rs_Vj_valid | ld_Vj_cdb) & (rs_Vk_valid | ld_Vk_cdb);
`else
  assign ready = rs_busy & rs_Vj_valid & rs_Vk_valid;
`endif

  assign exec_oh  = NUM_RS'(1) << exec_idx_q;
  assign accept   = (state_q == OFFER) & exec_ready & ~flush;
  assign next_ptr = (exec_idx_q == IDX_WIDTH'(NUM_RS-1)) ? '0 : exec_idx_q + 1'b1;
  // On a transfer the just-accepted entry is still busy, so it is masked out of reselection.
  assign sel_base = accept ? next_ptr : rr_ptr_q;
  assign cand     = ready & ~(accept ? exec_oh : '0);

  always_comb begin
    rot       = NUM_RS'({cand, cand} >> sel_base);
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = NUM_RS-1; k >= 0; k--) begin
      if (rot[k]) begin
        sel_found = 1'b1;
        sel_off   = IDX_WIDTH'(k);
      end
    end
    sel_sum = {1'b0, sel_base} + {1'b0, sel_off};
    if (sel_sum >= NUM_RS_W) sel_sum = sel_sum - NUM_RS_W;
    sel_idx = sel_sum[IDX_WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    exec_idx_d = exec_idx_q;
    rr_ptr_d   = rr_ptr_q;
    clr_busy   = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = OFFER;
          exec_idx_d = sel_idx;
        end
      end
      OFFER: begin
        if (accept) begin
          clr_busy = exec_oh;
          rr_ptr_d = next_ptr;
          if (sel_found) exec_idx_d = sel_idx;
          else           state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q    <= IDLE;
      exec_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      exec_idx_q <= exec_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign exec_valid = (state_q == OFFER);
  assign exec_idx   = exec_idx_q;

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: a behavioural reservation-station bank plus a scheduler reference
// model, driven by directed scenarios and a randomized run.
module tb_rs_scheduler;
  localparam int N  = 3;
  localparam int TW = 3;
  localparam int IW = 2;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          flush, issue_valid, issue_ready;
  logic [IW-1:0] alloc_idx;
  logic [N-1:0]  ld_issue, rs_busy, rs_Vj_valid, rs_Vk_valid;
  logic [N*TW-1:0] rs_Qj, rs_Qk;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [N-1:0]  ld_Vj_cdb, ld_Vk_cdb, clr_busy;
  logic          exec_valid;
  logic [IW-1:0] exec_idx;
  logic          exec_ready;

  rs_scheduler #(.NUM_RS(N), .TAG_WIDTH(TW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alloc_idx(alloc_idx), .ld_issue(ld_issue), .rs_busy(rs_busy),
    .rs_Vj_valid(rs_Vj_valid), .rs_Vk_valid(rs_Vk_valid), .rs_Qj(rs_Qj), .rs_Qk(rs_Qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ld_Vj_cdb(ld_Vj_cdb), .ld_Vk_cdb(ld_Vk_cdb),
    .clr_busy(clr_busy), .exec_valid(exec_valid), .exec_idx(exec_idx), .exec_ready(exec_ready)
  );

  // clock
  always #5 clk = ~clk;

  // reservation-station bank as the real entries would behave
  bit b_busy[N], b_vj[N], b_vk[N];
  int b_qj[N], b_qk[N];
  // scheduler reference: offer flag, offered entry, round-robin start
  bit m_valid;
  int m_idx, m_ptr;
  // current cycle controls and expectations shared between check and advance
  bit c_fl, c_iv, c_cv, c_er;
  int c_tag;
  bit e_vj[N], e_vk[N], m_rdy[N];
  bit e_free;
  int e_alloc;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_bank();
    for (int i = 0; i < N; i++) begin
      b_busy[i] = 0; b_vj[i] = 0; b_vk[i] = 0; b_qj[i] = 0; b_qk[i] = 0;
    end
  endtask

  task automatic drive(input bit fl, input bit iv, input bit cv, input int tag, input bit er);
    c_fl = fl; c_iv = iv; c_cv = cv; c_tag = tag; c_er = er;
    flush = fl; issue_valid = iv; cdb_valid = cv; cdb_tag = TW'(tag); exec_ready = er;
    for (int i = 0; i < N; i++) begin
      rs_busy[i]     = b_busy[i];
      rs_Vj_valid[i] = b_vj[i];
      rs_Vk_valid[i] = b_vk[i];
      rs_Qj[i*TW +: TW] = TW'(b_qj[i]);
      rs_Qk[i*TW +: TW] = TW'(b_qk[i]);
    end
    #1;
  endtask

  task automatic check_cycle();
    logic [N-1:0] x_vj, x_vk, x_ldi, x_clr;
    e_free = 0; e_alloc = 0;
    for (int i = 0; i < N; i++)
      if (!e_free && !b_busy[i]) begin e_free = 1; e_alloc = i; end
    for (int i = 0; i < N; i++) begin
      e_vj[i] = !c_fl && c_cv && b_busy[i] && !b_vj[i] && (b_qj[i] == c_tag);
      e_vk[i] = !c_fl && c_cv && b_busy[i] && !b_vk[i] && (b_qk[i] == c_tag);
      x_vj[i] = e_vj[i];
      x_vk[i] = e_vk[i];
      x_ldi[i] = !c_fl && c_iv && e_free && (i == e_alloc);
      x_clr[i] = !c_fl && m_valid && c_er && (i == m_idx);
    end
    chk("issue_ready", issue_ready, !c_fl && e_free);
    if (c_fl || e_free) chk("alloc_idx", alloc_idx, c_fl ? 0 : e_alloc);
    chk("ld_issue", ld_issue, x_ldi);
    chk("ld_Vj_cdb", ld_Vj_cdb, x_vj);
    chk("ld_Vk_cdb", ld_Vk_cdb, x_vk);
    chk("clr_busy", clr_busy, x_clr);
    chk("exec_valid", exec_valid, m_valid);
    if (m_valid) chk("exec_idx", exec_idx, m_idx);
  endtask

  function automatic int pick(input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (m_rdy[j] && j != excl) return j;
    end
    return -1;
  endfunction

  // apply the clock edge to the models, then move to just after the DUT's edge
  task automatic advance();
    int sel, old;
    for (int i = 0; i < N; i++)
      m_rdy[i] = b_busy[i] && (b_vj[i] || (BYP && e_vj[i])) && (b_vk[i] || (BYP && e_vk[i]));
    if (c_fl) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
      clear_bank();
    end else begin
      if (!m_valid) begin
        sel = pick(m_ptr, -1);
        if (sel >= 0) begin m_valid = 1; m_idx = sel; end
      end else if (c_er) begin
        old = m_idx;
        b_busy[old] = 0;
        m_ptr = (old + 1) % N;
        sel = pick(m_ptr, old);
        if (sel >= 0) m_idx = sel;
        else          m_valid = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (e_vj[i]) b_vj[i] = 1;
        if (e_vk[i]) b_vk[i] = 1;
      end
      if (c_iv && e_free) begin
        b_busy[e_alloc] = 1;
        b_vj[e_alloc] = ($urandom_range(0, 2) != 0);
        b_vk[e_alloc] = ($urandom_range(0, 2) != 0);
        b_qj[e_alloc] = $urandom_range(0, 3);
        b_qk[e_alloc] = $urandom_range(0, 3);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    drive(1, 0, 0, 0, 0);
    check_cycle();
    advance();
  endtask

  initial begin
    flush = 1; issue_valid = 0; cdb_valid = 0; cdb_tag = '0; exec_ready = 0;
    rs_busy = '0; rs_Vj_valid = '0; rs_Vk_valid = '0; rs_Qj = '0; rs_Qk = '0;
    clear_bank();
    m_valid = 0; m_idx = 0; m_ptr = 0;
    @(posedge clk);
    #1;

    // reset: two flush cycles, then release
    drive(1, 0, 0, 0, 0); check_cycle();
    chk("rst_exec_valid", exec_valid, 0);
    chk("rst_issue_ready", issue_ready, 0);
    advance();
    drive(1, 0, 0, 0, 0); check_cycle();
    chk("rst_exec_idx", exec_idx, 0);
    advance();
    drive(0, 0, 0, 0, 0); check_cycle();
    chk("rel_issue_ready", issue_ready, 1);
    chk("rel_alloc_idx", alloc_idx, 0);
    advance();

    // allocation around busy entries, then a full bank
    do_flush();
    b_busy[0] = 1; b_busy[1] = 1;
    drive(0, 1, 0, 0, 0); check_cycle();
    chk("alloc_ld_issue", ld_issue, 3'b100);
    chk("alloc_idx2", alloc_idx, 2);
    advance();
    for (int i = 0; i < N; i++) begin b_busy[i] = 1; b_vj[i] = 0; b_vk[i] = 0; end
    drive(0, 1, 0, 0, 0); check_cycle();
    chk("full_issue_ready", issue_ready, 0);
    chk("full_ld_issue", ld_issue, 0);
    advance();

    // CDB tag match and miss
    do_flush();
    b_busy[1] = 1; b_vj[1] = 0; b_qj[1] = 5; b_vk[1] = 1; b_qk[1] = 0;
    drive(0, 0, 1, 5, 0); check_cycle();
    chk("cdb_hit_vj", ld_Vj_cdb, 3'b010);
    chk("cdb_hit_vk", ld_Vk_cdb, 0);
    drive(0, 0, 1, 4, 0); check_cycle();
    chk("cdb_miss_vj", ld_Vj_cdb, 0);
    advance();

    // round-robin back-to-back dispatch
    do_flush();
    for (int i = 0; i < N; i++) begin b_busy[i] = 1; b_vj[i] = 1; b_vk[i] = 1; end
    drive(0, 0, 0, 0, 1); check_cycle(); advance();
    for (int k = 0; k < N; k++) begin
      drive(0, 0, 0, 0, 1); check_cycle();
      chk("rr_valid", exec_valid, 1);
      chk("rr_idx", exec_idx, k);
      chk("rr_clr", clr_busy, 1 << k);
      advance();
    end

    // stalled offer on entry 2
    do_flush();
    b_busy[2] = 1; b_vj[2] = 1; b_vk[2] = 1;
    drive(0, 0, 0, 0, 0); check_cycle(); advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0); check_cycle();
      chk("stall_valid", exec_valid, 1);
      chk("stall_idx", exec_idx, 2);
      chk("stall_clr", clr_busy, 0);
      advance();
    end
    drive(0, 0, 0, 0, 1); check_cycle();
    chk("stall_release_clr", clr_busy, 3'b100);
    advance();

    // last operand arriving on the CDB
    do_flush();
    b_busy[0] = 1; b_vj[0] = 1; b_vk[0] = 0; b_qk[0] = 3;
    drive(0, 0, 1, 3, 0); check_cycle();
    chk("wake_ld_vk", ld_Vk_cdb, 3'b001);
    chk("wake_t0_valid", exec_valid, 0);
    advance();
    drive(0, 0, 0, 0, 0); check_cycle();
    chk("wake_t1_valid", exec_valid, BYP);
    advance();
    drive(0, 0, 0, 0, 0); check_cycle();
    chk("wake_t2_valid", exec_valid, 1);
    advance();

    // randomized traffic with occasional flush
    do_flush();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 9) < 6);
      check_cycle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Controller for a bank of NUM_RS add reservation-station entries in the Tomasulo LC-3b core.
- Allocates a free entry on issue and drives its per-entry load enables.
- Snoops the CDB and asserts operand-capture enables on tag match.
- Picks one ready entry round-robin, offers it to the ALU through a valid/ready handshake, and frees the entry on acceptance.

Parameters:
- NUM_RS, 3, number of reservation-station entries (2..8).
- TAG_WIDTH, 3, width of ROB/producer tags (Qj/Qk, CDB tag).
- IDX_WIDTH, $clog2(NUM_RS), width of entry index outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- flush  in  1  reset; synchronous, active-high. Also used as the pipeline flush.
- issue_valid  in  1  decode has an add-class instruction to place.
- issue_ready  out  1  at least one entry is free.
- alloc_idx  out  IDX_WIDTH  entry that receives the issuing instruction.
- ld_issue  out  NUM_RS  one-hot; drives ld_op/ld_busy/ld_Vj/ld_Qj/ld_Vk/ld_Qk of the allocated entry.
- rs_busy  in  NUM_RS  busy_out of each entry.
- rs_Vj_valid  in  NUM_RS  Vj_valid_out of each entry.
- rs_Vk_valid  in  NUM_RS  Vk_valid_out of each entry.
- rs_Qj  in  NUM_RS*TAG_WIDTH  Qj_out of each entry; entry i at [i*TAG_WIDTH +: TAG_WIDTH].
- rs_Qk  in  NUM_RS*TAG_WIDTH  Qk_out of each entry; same packing.
- cdb_valid  in  1  CDB broadcast valid this cycle.
- cdb_tag  in  TAG_WIDTH  CDB producer tag.
- ld_Vj_cdb  out  NUM_RS  capture CDB data into Vj, set Vj_valid.
- ld_Vk_cdb  out  NUM_RS  capture CDB data into Vk, set Vk_valid.
- clr_busy  out  NUM_RS  one-hot; clear busy of the dispatched entry.
- exec_valid  out  1  registered; an entry is being offered to the ALU.
- exec_idx  out  IDX_WIDTH  registered; entry being offered.
- exec_ready  in  1  ALU accepts the offer this cycle.

Behaviour:
- Reset (flush=1 at edge):
  - exec_valid<=0, exec_idx<=0, rr_ptr<=0.
  - While flush=1, all combinational outputs are 0: issue_ready, ld_issue, ld_Vj_cdb, ld_Vk_cdb, clr_busy. alloc_idx=0.
- Allocation (combinational):
  - issue_ready = |~rs_busy.
  - alloc_idx = lowest index with rs_busy=0.
  - ld_issue = onehot(alloc_idx) when issue_valid & issue_ready, else 0.
  - An entry freed by clr_busy this cycle is not allocatable until next cycle.
- CDB wakeup (combinational, per entry i):
  - ld_Vj_cdb[i] = cdb_valid & rs_busy[i] & ~rs_Vj_valid[i] & (Qj_i==cdb_tag). Vk/Qk the same.
  - Both may assert on one entry in the same cycle.
  - An entry being allocated this cycle (busy=0) gets no CDB enable; issue-stage forwarding covers it.
- Ready: ready[i] = rs_busy[i] & rs_Vj_valid[i] & rs_Vk_valid[i] (see optional feature).
- Selection: first ready entry at or after rr_ptr, wrapping modulo NUM_RS.
- Dispatch FSM, IDLE (exec_valid=0):
  - If any ready entry exists, it is selected and registered next edge: exec_valid<=1, exec_idx<=sel.
- Dispatch FSM, OFFER (exec_valid=1):
  - exec_idx is held stable until exec_ready=1.
  - On exec_valid & exec_ready: clr_busy[exec_idx]=1 that cycle and rr_ptr<=(exec_idx+1) mod NUM_RS.
  - Same edge: reselect among ready entries excluding exec_idx, so back-to-back dispatch happens if another is ready; else exec_valid<=0.
- Latency:
  - Entry ready in cycle t gives exec_valid=1 in t+1 when idle.
  - Sustained throughput is 1 dispatch/cycle.
- Concurrency: issue, CDB wakeup and dispatch free all proceed in the same cycle without interaction.
- flush mid-offer drops the offer; no clr_busy is issued. Entries are cleared by the same flush.

Optional Feature:
- RS_WAKEUP_BYPASS_EN defined:
  - ready[i] also counts an operand as valid when its ld_V*_cdb[i] is asserted this cycle.
  - An entry whose last operand arrives on the CDB can be registered for dispatch at the same edge.
- Undefined: ready uses registered valid bits only, adding one cycle of wakeup latency.

Test Plan:
- Reset: flush=1 for 2 cycles, all rs_busy=0 -> exec_valid=0, issue_ready=0 during flush; after release issue_ready=1, alloc_idx=0.
- Allocation: rs_busy=3'b011, issue_valid=1 -> ld_issue=3'b100, alloc_idx=2. With rs_busy=3'b111 -> issue_ready=0, ld_issue=0.
- CDB wakeup: entry1 busy, Vj_valid=0, Qj=5; cdb_valid=1, cdb_tag=5 -> ld_Vj_cdb=3'b010. cdb_tag=4 -> 0.
- Round-robin: all 3 entries ready, exec_ready=1 held -> exec_idx sequence 0,1,2 on consecutive cycles, each with a matching clr_busy pulse.
- Stall: entry2 offered, exec_ready=0 for 3 cycles -> exec_idx=2, exec_valid=1 stable and clr_busy=0 throughout; exec_ready=1 -> clr_busy=3'b100.
- Wakeup bypass: entry0 Vk_valid=0, Qk=3, CDB tag 3 at cycle t -> exec_valid=1 at t+1 with RS_WAKEUP_BYPASS_EN, at t+2 without.
